// File: rtl/clk_div_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_gen_pkg : shared FSM encodings and constants for clk_div_gen
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package clk_div_gen_pkg;

    typedef enum logic [0:0] {
        ST_LOCKING = 1'b0,
        ST_LOCKED  = 1'b1
    } top_state_t;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_HIGH = 2'd1,
        CH_LOW  = 2'd2
    } ch_state_t;

    localparam int DEFAULT_DIV = 1;

endpackage
`default_nettype wire

// File: rtl/clk_div_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_gen_if : control/status bundle of clk_div_gen              |
// | Optional macro: CLK_DIV_GEN_RELOCK_CNT_EN adds RELOCK_CNT_OUT      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface clk_div_gen_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    logic [NUM_CH*DIV_W-1:0] DIV_IN;
    logic                    DIV_LOAD_IN;
    logic [NUM_CH-1:0]       CLK_EN_IN;
    logic [NUM_CH-1:0]       CLK_OUT;
    logic [NUM_CH-1:0]       TICK_OUT;
    logic                    LOCKED_OUT;
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
    logic [7:0]              RELOCK_CNT_OUT;
`endif

    modport master (
        output DIV_IN,
        output DIV_LOAD_IN,
        output CLK_EN_IN,
        input  CLK_OUT,
        input  TICK_OUT,
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        input  RELOCK_CNT_OUT,
`endif
        input  LOCKED_OUT
    );

    modport slave (
        input  DIV_IN,
        input  DIV_LOAD_IN,
        input  CLK_EN_IN,
        output CLK_OUT,
        output TICK_OUT,
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        output RELOCK_CNT_OUT,
`endif
        output LOCKED_OUT
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_ch : one divided-clock channel (IDLE/HIGH/LOW phase FSM)   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module clk_div_ch
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             go,
    input  wire logic             en,
    input  wire logic [DIV_W-1:0] div,
    output logic                  clk_out,
    output logic                  tick_out
);

    ch_state_t        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic             clk_nxt, tick_nxt;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] last;

    assign div_eff = (div == '0) ? DIV_W'(DEFAULT_DIV) : div;
    assign last    = div_eff - DIV_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clk_out  <= clk_nxt;
            tick_out <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clk_out;
        tick_nxt  = 1'b0;
        // go is the lock state for the coming edge, so a held enable rises with LOCKED_OUT
        if (!go) begin
            state_nxt = CH_IDLE;
            cnt_nxt   = '0;
            clk_nxt   = 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    clk_nxt = 1'b0;
                    if (en) begin
                        state_nxt = CH_HIGH;
                        cnt_nxt   = '0;
                        clk_nxt   = 1'b1;
                        tick_nxt  = 1'b1;
                    end
                end
                CH_HIGH: begin
                    if (cnt == last) begin
                        state_nxt = CH_LOW;
                        cnt_nxt   = '0;
                        clk_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + DIV_W'(1);
                    end
                end
                CH_LOW: begin
                    if (!en) begin
                        state_nxt = CH_IDLE;
                        cnt_nxt   = '0;
                        clk_nxt   = 1'b0;
                    end else if (cnt == last) begin
                        state_nxt = CH_HIGH;
                        cnt_nxt   = '0;
                        clk_nxt   = 1'b1;
                        tick_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state_nxt = CH_IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clk_div_gen : multi-channel divided clock generator with lock seq. |
// | Optional macro: CLK_DIV_GEN_RELOCK_CNT_EN (relock pulse counter)   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int LOCK_W      = 5
) (
    input  wire logic   CLKIN_IN,
    input  wire logic   RSTN_IN,
    clk_div_gen_if.slave bus
);

    top_state_t              state, state_nxt;
    logic [LOCK_W-1:0]       lock_cnt, lock_cnt_nxt;
    logic [NUM_CH*DIV_W-1:0] div_reg;
    logic                    go;
    logic [NUM_CH-1:0]       clk_vec;
    logic [NUM_CH-1:0]       tick_vec;

    always_ff @(posedge CLKIN_IN) begin
        if (!RSTN_IN) begin
            state    <= ST_LOCKING;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ST_LOCKING: begin
                if (bus.DIV_LOAD_IN) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    state_nxt    = ST_LOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                end
            end
            ST_LOCKED: begin
                if (bus.DIV_LOAD_IN) begin
                    state_nxt    = ST_LOCKING;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_LOCKING;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLKIN_IN) begin
        if (!RSTN_IN) begin
            div_reg <= {NUM_CH{DIV_W'(DEFAULT_DIV)}};
        end else if (bus.DIV_LOAD_IN) begin
            div_reg <= bus.DIV_IN;
        end
    end

    assign go             = (state_nxt == ST_LOCKED);
    assign bus.LOCKED_OUT = (state == ST_LOCKED);
    assign bus.CLK_OUT    = clk_vec;
    assign bus.TICK_OUT   = tick_vec;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            clk_div_ch #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk      (CLKIN_IN),
                .rst_n    (RSTN_IN),
                .go       (go),
                .en       (bus.CLK_EN_IN[k]),
                .div      (div_reg[k*DIV_W +: DIV_W]),
                .clk_out  (clk_vec[k]),
                .tick_out (tick_vec[k])
            );
        end
    endgenerate

`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
    logic [7:0] relock_cnt;

    always_ff @(posedge CLKIN_IN) begin
        if (!RSTN_IN) begin
            relock_cnt <= 8'd0;
        end else if (bus.DIV_LOAD_IN && (state == ST_LOCKED) && (relock_cnt != 8'hFF)) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end

    assign bus.RELOCK_CNT_OUT = relock_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_clk_div_gen : scoreboard bench for clk_div_gen (2 ch, lock 16)  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_clk_div_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int F_CLK  = 0;
    localparam int F_TICK = 1;
    localparam int F_LOCK = 2;
    localparam int F_RCNT = 3;

    typedef struct {
        int         cyc;
        int         fld;
        logic [7:0] mask;
        logic [7:0] val;
        string      nm;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (16),
        .LOCK_W      (5)
    ) dut (
        .CLKIN_IN (clk),
        .RSTN_IN  (rstn),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int f, input logic [7:0] m,
                             input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.fld = f; e.mask = m; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every edge, pop expectations due now and compare
    initial begin
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    act = 8'd0;
                    case (q[i].fld)
                        F_CLK:  act = 8'(bus.CLK_OUT);
                        F_TICK: act = 8'(bus.TICK_OUT);
                        F_LOCK: act = 8'(bus.LOCKED_OUT);
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
                        F_RCNT: act = bus.RELOCK_CNT_OUT;
`endif
                        default: act = 8'd0;
                    endcase
                    n_checks++;
                    if (q[i].cyc < cyc) begin
                        n_fail++;
                        $display("FAIL %s: stale expectation for edge %0d seen at edge %0d",
                                 q[i].nm, q[i].cyc, cyc);
                    end else if ((act & q[i].mask) !== (q[i].val & q[i].mask)) begin
                        n_fail++;
                        $display("FAIL %s @edge %0d: got 0x%02h, want 0x%02h (mask 0x%02h)",
                                 q[i].nm, cyc, act & q[i].mask, q[i].val & q[i].mask, q[i].mask);
                    end
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        int l;
        bus.DIV_IN      = '0;
        bus.DIV_LOAD_IN = 1'b0;
        bus.CLK_EN_IN   = 2'b11;
        rstn            = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state and first lock with default divisors
        c = cyc;
        expect_at(c+1, F_LOCK, 8'h01, 8'h00, "rst_locked");
        expect_at(c+1, F_CLK,  8'h03, 8'h00, "rst_clk");
        expect_at(c+1, F_TICK, 8'h03, 8'h00, "rst_tick");
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        expect_at(c+1, F_RCNT, 8'hFF, 8'h00, "rst_relock_cnt");
`endif
        @(negedge clk);
        r = cyc;
        rstn = 1'b1;
        expect_at(r+15, F_LOCK, 8'h01, 8'h00, "lock_not_early");
        expect_at(r+15, F_CLK,  8'h03, 8'h00, "clk_low_prelock");
        expect_at(r+16, F_LOCK, 8'h01, 8'h01, "lock_rise");
        expect_at(r+16, F_CLK,  8'h03, 8'h03, "clk_rise_with_lock");
        expect_at(r+16, F_TICK, 8'h03, 8'h03, "tick_with_lock");
        expect_at(r+17, F_CLK,  8'h03, 8'h00, "div1_low");
        expect_at(r+17, F_TICK, 8'h03, 8'h00, "div1_tick_low");
        expect_at(r+18, F_CLK,  8'h03, 8'h03, "div1_high2");
        expect_at(r+18, F_TICK, 8'h03, 8'h03, "div1_tick2");
        wait_cyc(r+20);

        // Load ch0=3, ch1=0 while locked
        c = cyc;
        bus.DIV_IN = {8'd0, 8'd3};
        bus.DIV_LOAD_IN = 1'b1;
        expect_at(c+1,  F_LOCK, 8'h01, 8'h00, "load_unlock");
        expect_at(c+1,  F_CLK,  8'h03, 8'h00, "load_clk_off");
        expect_at(c+16, F_LOCK, 8'h01, 8'h00, "relock_not_early");
        expect_at(c+17, F_LOCK, 8'h01, 8'h01, "relock");
        expect_at(c+17, F_CLK,  8'h03, 8'h03, "d3_rise");
        expect_at(c+17, F_TICK, 8'h03, 8'h03, "d3_tick");
        expect_at(c+18, F_CLK,  8'h03, 8'h01, "d3_c1");
        expect_at(c+18, F_TICK, 8'h03, 8'h00, "d3_t1");
        expect_at(c+19, F_CLK,  8'h03, 8'h03, "d3_c2");
        expect_at(c+19, F_TICK, 8'h03, 8'h02, "d3_t2");
        expect_at(c+20, F_CLK,  8'h03, 8'h00, "d3_c3");
        expect_at(c+21, F_CLK,  8'h03, 8'h02, "d3_c4");
        expect_at(c+22, F_CLK,  8'h03, 8'h00, "d3_c5");
        expect_at(c+23, F_CLK,  8'h03, 8'h03, "d3_c6");
        expect_at(c+23, F_TICK, 8'h03, 8'h03, "d3_t6");
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        expect_at(c+1,  F_RCNT, 8'hFF, 8'h01, "relock_cnt_1");
`endif
        @(negedge clk);
        bus.DIV_LOAD_IN = 1'b0;
        wait_cyc(c+25);

        // ch0 div=4, enable dropped in 2nd high cycle
        c = cyc;
        l = c + 1;
        bus.DIV_IN = {8'd0, 8'd4};
        bus.DIV_LOAD_IN = 1'b1;
        expect_at(l+16, F_CLK, 8'h03, 8'h03, "d4_rise");
        expect_at(l+17, F_CLK, 8'h03, 8'h01, "d4_c1");
        expect_at(l+18, F_CLK, 8'h03, 8'h03, "d4_c2");
        expect_at(l+19, F_CLK, 8'h03, 8'h01, "d4_c3");
        expect_at(l+20, F_CLK, 8'h03, 8'h02, "d4_fall");
        expect_at(l+21, F_CLK, 8'h03, 8'h00, "d4_idle");
        expect_at(l+22, F_CLK, 8'h03, 8'h02, "d4_ch1_run");
        expect_at(l+24, F_CLK, 8'h03, 8'h02, "d4_ch1_run2");
        expect_at(l+28, F_CLK, 8'h03, 8'h02, "d4_ch0_stays");
        for (int k = l + 17; k <= l + 30; k++)
            expect_at(k, F_TICK, 8'h01, 8'h00, "d4_no_tick0");
        expect_at(l+24, F_TICK, 8'h02, 8'h02, "d4_tick1");
        @(negedge clk);
        bus.DIV_LOAD_IN = 1'b0;
        wait_cyc(l+17);
        bus.CLK_EN_IN = 2'b10;
        wait_cyc(l+32);

        // Reset and load on the same edge: reset wins
        c = cyc;
        rstn = 1'b0;
        bus.DIV_LOAD_IN = 1'b1;
        bus.DIV_IN = {8'd5, 8'd5};
        bus.CLK_EN_IN = 2'b11;
        expect_at(c+1,  F_LOCK, 8'h01, 8'h00, "rstload_locked");
        expect_at(c+1,  F_CLK,  8'h03, 8'h00, "rstload_clk");
        expect_at(c+17, F_LOCK, 8'h01, 8'h01, "rstload_lock");
        expect_at(c+17, F_CLK,  8'h03, 8'h03, "rstload_rise");
        expect_at(c+18, F_CLK,  8'h03, 8'h00, "rstload_div1");
        expect_at(c+19, F_CLK,  8'h03, 8'h03, "rstload_div1b");
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        expect_at(c+1,  F_RCNT, 8'hFF, 8'h00, "rstload_relock_cnt");
`endif
        @(negedge clk);
        rstn = 1'b1;
        bus.DIV_LOAD_IN = 1'b0;
        wait_cyc(c+22);

        // Load during LOCKING at count 10 restarts the lock count
        c = cyc;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        expect_at(c+17, F_LOCK, 8'h01, 8'h00, "midlock_no_lock");
        expect_at(c+27, F_LOCK, 8'h01, 8'h00, "midlock_not_early");
        expect_at(c+28, F_LOCK, 8'h01, 8'h01, "midlock_lock");
        expect_at(c+28, F_CLK,  8'h03, 8'h03, "midlock_rise");
        expect_at(c+28, F_TICK, 8'h03, 8'h03, "midlock_tick");
        expect_at(c+29, F_CLK,  8'h03, 8'h01, "midlock_d2");
        expect_at(c+30, F_CLK,  8'h03, 8'h02, "midlock_d2b");
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        expect_at(c+28, F_RCNT, 8'hFF, 8'h00, "locking_load_uncounted");
`endif
        wait_cyc(c+11);
        bus.DIV_IN = {8'd1, 8'd2};
        bus.DIV_LOAD_IN = 1'b1;
        @(negedge clk);
        bus.DIV_LOAD_IN = 1'b0;
        wait_cyc(c+32);

        // Maximum divisor 255
        c = cyc;
        l = c + 1;
        bus.DIV_IN = {8'd1, 8'd255};
        bus.DIV_LOAD_IN = 1'b1;
        expect_at(l+16,  F_CLK,  8'h01, 8'h01, "d255_rise");
        expect_at(l+16,  F_TICK, 8'h01, 8'h01, "d255_tick");
        expect_at(l+270, F_CLK,  8'h01, 8'h01, "d255_last_high");
        expect_at(l+270, F_TICK, 8'h01, 8'h00, "d255_no_tick");
        expect_at(l+271, F_CLK,  8'h01, 8'h00, "d255_fall");
        expect_at(l+525, F_CLK,  8'h01, 8'h00, "d255_last_low");
        expect_at(l+526, F_CLK,  8'h01, 8'h01, "d255_rise2");
        expect_at(l+526, F_TICK, 8'h01, 8'h01, "d255_tick2");
`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        expect_at(l, F_RCNT, 8'hFF, 8'h01, "relock_cnt_after_reset");
`endif
        @(negedge clk);
        bus.DIV_LOAD_IN = 1'b0;
        wait_cyc(l+530);

`ifdef CLK_DIV_GEN_RELOCK_CNT_EN
        // 300 loads while locked saturate the counter
        bus.DIV_IN = {8'd1, 8'd1};
        for (int n = 0; n < 300; n++) begin
            c = cyc;
            bus.DIV_LOAD_IN = 1'b1;
            @(negedge clk);
            bus.DIV_LOAD_IN = 1'b0;
            wait_cyc(c+17);
        end
        expect_at(cyc+1, F_RCNT, 8'hFF, 8'hFF, "relock_cnt_sat");
        expect_at(cyc+1, F_LOCK, 8'h01, 8'h01, "relock_cnt_locked");
        wait_cyc(cyc+3);
`endif

        wait_cyc(cyc+3);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
